// File: rtl/ex_multicycle.sv
// Multicycle execute stage: logic, shift, add/sub/compare and an optional iterative divider.
// Define EX_DIV_EN to build the restoring radix-2 DIV/DIVU unit; otherwise divide ops yield zero.
module ex_multicycle #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      aluop_i,
  input  logic [2:0]      alusel_i,
  input  logic [XLEN-1:0] reg1_i,
  input  logic [XLEN-1:0] reg2_i,
  input  logic [RAW-1:0]  wd_i,
  input  logic            wreg_i,
  input  logic            flush_i,
  output logic [RAW-1:0]  wd_o,
  output logic            wreg_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rem_o,
  output logic            rem_we_o,
  output logic            stallreq_o
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = SHW + 1;

  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_NOT_OP  = 8'b0010_1101;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
  localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;
  localparam logic [2:0] EXE_RES_DIV   = 3'b110;

  logic [XLEN-1:0] logic_res;
  logic [XLEN-1:0] shift_res;
  logic [XLEN-1:0] arith_res;
  logic [XLEN-1:0] sel_res;
  logic [SHW-1:0]  shamt;
  logic            is_div_op;
  logic            div_busy;
  logic            div_done;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] div_r;

  assign shamt     = reg1_i[SHW-1:0];
  assign is_div_op = (alusel_i == EXE_RES_DIV) &&
                     ((aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP));

  // Bitwise logic group
  always_comb begin
    logic_res = '0;
    case (aluop_i)
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      EXE_NOT_OP: logic_res = ~reg1_i;
      default:    logic_res = '0;
    endcase
  end

  // Shifts move reg2 by the low bits of reg1
  always_comb begin
    shift_res = '0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << shamt;
      EXE_SRL_OP: shift_res = reg2_i >> shamt;
      EXE_SRA_OP: shift_res = XLEN'($signed(reg2_i) >>> shamt);
      default:    shift_res = '0;
    endcase
  end

  always_comb begin
    arith_res = '0;
    case (aluop_i)
      EXE_ADD_OP:  arith_res = reg1_i + reg2_i;
      EXE_SUB_OP:  arith_res = reg1_i - reg2_i;
      EXE_SLT_OP:  arith_res = XLEN'($signed(reg1_i) < $signed(reg2_i));
      EXE_SLTU_OP: arith_res = XLEN'(reg1_i < reg2_i);
      default:     arith_res = '0;
    endcase
  end

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  div_state_e      state;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvsr;
  logic [CW-1:0]   cnt;
  logic            neg_q;
  logic            neg_r;
  logic            signed_op;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [XLEN:0]   partial;
  logic [XLEN:0]   diff;

  assign signed_op = (aluop_i == EXE_DIV_OP);
  assign mag1      = (signed_op && reg1_i[XLEN-1]) ? (~reg1_i + XLEN'(1)) : reg1_i;
  assign mag2      = (signed_op && reg2_i[XLEN-1]) ? (~reg2_i + XLEN'(1)) : reg2_i;

  // Partial remainder always stays below twice the divisor, so diff[XLEN] is the borrow
  assign partial = {rem, quo[XLEN-1]};
  assign diff    = partial - {1'b0, dvsr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      quo   <= '0;
      rem   <= '0;
      dvsr  <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (flush_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_div_op) begin
            if (reg2_i == '0) begin
              quo   <= '1;
              rem   <= reg1_i;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_DONE;
            end else begin
              quo   <= mag1;
              rem   <= '0;
              dvsr  <= mag2;
              neg_q <= signed_op && (reg1_i[XLEN-1] ^ reg2_i[XLEN-1]);
              neg_r <= signed_op && reg1_i[XLEN-1];
              cnt   <= '0;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (!diff[XLEN]) begin
            rem <= diff[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= partial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN - 1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign div_busy = (state == S_CALC) || ((state == S_IDLE) && is_div_op);
  assign div_done = (state == S_DONE);
  assign div_q    = neg_q ? (~quo + XLEN'(1)) : quo;
  assign div_r    = neg_r ? (~rem + XLEN'(1)) : rem;
`else
  logic unused_clk;

  assign unused_clk = clk;
  assign div_busy   = 1'b0;
  assign div_done   = 1'b0;
  assign div_q      = '0;
  assign div_r      = '0;
`endif

  // Result select; the divide result is only visible once the FSM reports done
  always_comb begin
    sel_res = '0;
    case (alusel_i)
      EXE_RES_LOGIC: sel_res = logic_res;
      EXE_RES_SHIFT: sel_res = shift_res;
      EXE_RES_ARITH: sel_res = arith_res;
      EXE_RES_DIV:   sel_res = (div_done && is_div_op) ? div_q : '0;
      default:       sel_res = '0;
    endcase
  end

  // Reset and flush override every request leaving the stage
  assign wd_o       = rst ? wd_i : '0;
  assign wdata_o    = rst ? sel_res : '0;
  assign wreg_o     = rst && !flush_i && !div_busy && wreg_i;
  assign rem_o      = (rst && div_done) ? div_r : '0;
  assign rem_we_o   = rst && !flush_i && div_done;
  assign stallreq_o = rst && !flush_i && div_busy;

endmodule

// File: tb/tb_ex_multicycle.sv
// Directed self-checking bench for ex_multicycle (XLEN=32); divider scenarios follow EX_DIV_EN.
module tb_ex_multicycle;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RAW  = 5;

  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_NOT  = 8'b0010_1101;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_ADD  = 8'b0010_0000;
  localparam logic [7:0] OP_SUB  = 8'b0010_0010;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;

  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_ARITH = 3'b100;
  localparam logic [2:0] RES_DIV   = 3'b110;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      aluop_i;
  logic [2:0]      alusel_i;
  logic [XLEN-1:0] reg1_i;
  logic [XLEN-1:0] reg2_i;
  logic [RAW-1:0]  wd_i;
  logic            wreg_i;
  logic            flush_i;
  logic [RAW-1:0]  wd_o;
  logic            wreg_o;
  logic [XLEN-1:0] wdata_o;
  logic [XLEN-1:0] rem_o;
  logic            rem_we_o;
  logic            stallreq_o;

  int n_checks = 0;
  int n_fail   = 0;

  ex_multicycle #(.XLEN(XLEN), .RAW(RAW)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .alusel_i   (alusel_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .flush_i    (flush_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .rem_o      (rem_o),
    .rem_we_o   (rem_we_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; flush_i = 1'b0;
    aluop_i = OP_ADD; alusel_i = RES_ARITH; reg1_i = 32'd3; reg2_i = 32'd4;
    wd_i = 5'd5; wreg_i = 1'b1;
    #2;
    n_checks++;
    if ({wd_o, wreg_o, wdata_o, rem_o, rem_we_o, stallreq_o} !== '0)
      $display("FAIL reset_outputs: got wd=%h wreg=%b wdata=%h rem=%h rem_we=%b stall=%b, expected all 0",
               wd_o, wreg_o, wdata_o, rem_o, rem_we_o, stallreq_o);
    else ;
    if ({wd_o, wreg_o, wdata_o, rem_o, rem_we_o, stallreq_o} !== '0) n_fail++;
    @(negedge clk); rst = 1'b1;
    #1;
    n_checks++;
    if (wdata_o !== 32'd7 || wd_o !== 5'd5 || wreg_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_add: got wdata=%h wd=%h wreg=%b, expected 7/5/1", wdata_o, wd_o, wreg_o);
    end
  endtask

  task automatic test_logic();
    logic [7:0]  ops  [6] = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_NOT, 8'h00};
    logic [31:0] as   [6] = '{32'hF0F0_0000, 32'hFF00_FF00, 32'hFFFF_0000, 32'hF000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    logic [31:0] bs   [6] = '{32'h0F0F_00FF, 32'h0FF0_0FF0, 32'h0F0F_0F0F, 32'h0000_000F, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps [6] = '{32'hFFFF_00FF, 32'h0F00_0F00, 32'hF0F0_0F0F, 32'h0FFF_FFF0, 32'hEDCB_A987, 32'h0000_0000};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      aluop_i = ops[i]; alusel_i = RES_LOGIC; reg1_i = as[i]; reg2_i = bs[i];
      wd_i = 5'(i + 1); wreg_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if (wdata_o !== exps[i]) begin
        n_fail++;
        $display("FAIL logic_%0d: got %h expected %h", i, wdata_o, exps[i]);
      end
      n_checks++;
      if (wd_o !== 5'(i + 1) || wreg_o !== 1'b1 || stallreq_o !== 1'b0) begin
        n_fail++;
        $display("FAIL logic_pass_%0d: got wd=%h wreg=%b stall=%b expected wd=%h wreg=1 stall=0",
                 i, wd_o, wreg_o, stallreq_o, 5'(i + 1));
      end
    end
  endtask

  task automatic test_shift();
    logic [7:0]  ops  [6] = '{OP_SRA, OP_SLL, OP_SRL, OP_SLL, OP_SRA, OP_SRL};
    logic [31:0] as   [6] = '{32'd4, 32'd8, 32'd31, 32'd33, 32'd0, 32'd4};
    logic [31:0] bs   [6] = '{32'h8000_0010, 32'h0000_00F1, 32'h8000_0000, 32'h0000_0003, 32'h8000_0000, 32'hF000_0000};
    logic [31:0] exps [6] = '{32'hF800_0001, 32'h0000_F100, 32'h0000_0001, 32'h0000_0006, 32'h8000_0000, 32'h0F00_0000};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      aluop_i = ops[i]; alusel_i = RES_SHIFT; reg1_i = as[i]; reg2_i = bs[i];
      wd_i = 5'd9; wreg_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if (wdata_o !== exps[i]) begin
        n_fail++;
        $display("FAIL shift_%0d: got %h expected %h", i, wdata_o, exps[i]);
      end
    end
  endtask

  task automatic test_arith();
    logic [7:0]  ops  [8] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLT, OP_SLTU, OP_SLTU, OP_ADD, OP_SLT};
    logic [2:0]  sels [8] = '{RES_ARITH, RES_ARITH, RES_ARITH, RES_ARITH, RES_ARITH, RES_ARITH, 3'b111, RES_ARITH};
    logic [31:0] as   [8] = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'd3, 32'h8000_0000};
    logic [31:0] bs   [8] = '{32'h2, 32'h1, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h1, 32'd4, 32'h7FFF_FFFF};
    logic [31:0] exps [8] = '{32'h1, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h1, 32'h0, 32'h0, 32'h1};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      aluop_i = ops[i]; alusel_i = sels[i]; reg1_i = as[i]; reg2_i = bs[i];
      wd_i = 5'd17; wreg_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if (wdata_o !== exps[i] || wreg_o !== 1'b1 || wd_o !== 5'd17) begin
        n_fail++;
        $display("FAIL arith_%0d: got wdata=%h wreg=%b wd=%h expected %h/1/11", i, wdata_o, wreg_o, wd_o, exps[i]);
      end
    end
  endtask

  task automatic test_flush_wreg();
    @(posedge clk); #1;
    aluop_i = OP_ADD; alusel_i = RES_ARITH; reg1_i = 32'd1; reg2_i = 32'd1;
    wd_i = 5'd2; wreg_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wreg_o !== 1'b0 || rem_we_o !== 1'b0 || stallreq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_alu: got wreg=%b rem_we=%b stall=%b expected 0/0/0", wreg_o, rem_we_o, stallreq_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
  endtask

`ifdef EX_DIV_EN
  task automatic test_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic [31:0] exp_r, input int exp_cyc,
                          input string name);
    int done_cyc;
    int stall_cnt;
    int early_wr;
    logic [31:0] got_q;
    logic [31:0] got_r;
    logic        got_stall;
    logic        got_wreg;
    done_cyc = -1; stall_cnt = 0; early_wr = 0;
    got_q = '0; got_r = '0; got_stall = 1'b1; got_wreg = 1'b0;
    @(posedge clk); #1;
    aluop_i = op; alusel_i = RES_DIV; reg1_i = a; reg2_i = b; wd_i = 5'd7; wreg_i = 1'b1;
    for (int c = 0; c <= exp_cyc + 4 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (stallreq_o === 1'b1) stall_cnt++;
      if (rem_we_o === 1'b1) begin
        done_cyc = c; got_q = wdata_o; got_r = rem_o; got_stall = stallreq_o; got_wreg = wreg_o;
      end else if (wreg_o !== 1'b0) begin
        early_wr++;
      end
    end
    n_checks++;
    if (done_cyc != exp_cyc) begin
      n_fail++;
      $display("FAIL %s_latency: got done cycle %0d expected %0d", name, done_cyc, exp_cyc);
    end
    n_checks++;
    if (stall_cnt != exp_cyc) begin
      n_fail++;
      $display("FAIL %s_stall_len: got %0d expected %0d", name, stall_cnt, exp_cyc);
    end
    n_checks++;
    if (got_q !== exp_q || got_r !== exp_r) begin
      n_fail++;
      $display("FAIL %s_result: got q=%h r=%h expected q=%h r=%h", name, got_q, got_r, exp_q, exp_r);
    end
    n_checks++;
    if (got_stall !== 1'b0 || got_wreg !== 1'b1 || early_wr != 0) begin
      n_fail++;
      $display("FAIL %s_ctrl: got done_stall=%b done_wreg=%b early_wreg=%0d expected 0/1/0",
               name, got_stall, got_wreg, early_wr);
    end
  endtask

  task automatic test_divide();
    test_div(OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "div_m7_2");
    test_div(OP_DIVU, 32'd100,       32'd0,        32'hFFFF_FFFF, 32'd100,       1,  "divu_by0");
    test_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,        33, "div_ovf");
    test_div(OP_DIV,  32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB, 1,  "div_neg_by0");
    test_div(OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        33, "div_7_m2");
    test_div(OP_DIVU, 32'hFFFF_FFFF, 32'd16,       32'h0FFF_FFFF, 32'd15,        33, "divu_max_16");
  endtask

  task automatic test_back_to_back();
    test_div(OP_DIVU, 32'd100,       32'd7, 32'd14,        32'd2,         33, "b2b_first");
    test_div(OP_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, "b2b_second");
    @(posedge clk); #1;
    aluop_i = 8'h00; alusel_i = 3'b000; wreg_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rem_we_o !== 1'b0 || stallreq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got rem_we=%b stall=%b expected 0/0", rem_we_o, stallreq_o);
    end
  endtask

  task automatic test_flush_div();
    int bad;
    @(posedge clk); #1;
    aluop_i = OP_DIV; alusel_i = RES_DIV; reg1_i = 32'd1000; reg2_i = 32'd3; wd_i = 5'd4; wreg_i = 1'b1;
    repeat (10) @(posedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stallreq_o !== 1'b0 || rem_we_o !== 1'b0 || wreg_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_calc: got stall=%b rem_we=%b wreg=%b expected 0/0/0", stallreq_o, rem_we_o, wreg_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0; aluop_i = OP_ADD; alusel_i = RES_ARITH; reg1_i = 32'd3; reg2_i = 32'd4;
    @(negedge clk);
    n_checks++;
    if (wdata_o !== 32'd7 || stallreq_o !== 1'b0 || wreg_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_then_add: got wdata=%h stall=%b wreg=%b expected 7/0/1", wdata_o, stallreq_o, wreg_o);
    end
    bad = 0;
    repeat (36) begin
      @(negedge clk);
      if (rem_we_o !== 1'b0 || stallreq_o !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL flush_no_rem_we: got %0d bad cycles expected 0", bad);
    end
    // Flush landing on the DONE cycle suppresses the write-back
    @(posedge clk); #1;
    aluop_i = OP_DIVU; alusel_i = RES_DIV; reg1_i = 32'd100; reg2_i = 32'd0;
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rem_we_o !== 1'b0 || wreg_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done: got rem_we=%b wreg=%b expected 0/0", rem_we_o, wreg_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0; aluop_i = 8'h00; alusel_i = 3'b000;
  endtask

  task automatic test_reset_mid_calc();
    @(posedge clk); #1;
    aluop_i = OP_DIVU; alusel_i = RES_DIV; reg1_i = 32'd500; reg2_i = 32'd7; wd_i = 5'd3; wreg_i = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if ({wd_o, wreg_o, wdata_o, rem_o, rem_we_o, stallreq_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_calc: got wd=%h wreg=%b wdata=%h rem=%h rem_we=%b stall=%b expected all 0",
               wd_o, wreg_o, wdata_o, rem_o, rem_we_o, stallreq_o);
    end
    aluop_i = 8'h00; alusel_i = 3'b000;
    @(negedge clk); rst = 1'b1;
    test_div(OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 33, "divu_after_reset");
  endtask
`else
  task automatic test_div_disabled();
    @(posedge clk); #1;
    aluop_i = OP_DIV; alusel_i = RES_DIV; reg1_i = 32'd100; reg2_i = 32'd7; wd_i = 5'd6; wreg_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (wdata_o !== 32'd0 || rem_o !== 32'd0 || rem_we_o !== 1'b0 || stallreq_o !== 1'b0) begin
        n_fail++;
        $display("FAIL div_disabled_%0d: got wdata=%h rem=%h rem_we=%b stall=%b expected 0/0/0/0",
                 c, wdata_o, rem_o, rem_we_o, stallreq_o);
      end
    end
    @(posedge clk); #1;
    aluop_i = OP_DIVU; reg2_i = 32'd0;
    @(negedge clk);
    n_checks++;
    if (wdata_o !== 32'd0 || rem_we_o !== 1'b0 || stallreq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL divu_by0_disabled: got wdata=%h rem_we=%b stall=%b expected 0/0/0", wdata_o, rem_we_o, stallreq_o);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_logic();
    test_shift();
    test_arith();
    test_flush_wreg();
`ifdef EX_DIV_EN
    test_divide();
    test_back_to_back();
    test_flush_div();
    test_reset_mid_calc();
`else
    test_div_disabled();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_multicycle.md
# ex_multicycle

Parametrised execute stage that succeeds the single-cycle logic-only execute unit. It adds shift, add/subtract and compare operations, and an optional iterative signed/unsigned divider that stalls the pipeline while it runs. It sits between the ID/EX and EX/MEM pipeline registers and drives the write-back request, the divide remainder and the stall request.

## Interface
Parameters:
- `XLEN`, default 32: datapath width. Must be a power of two and at least 8.
- `RAW`, default 5: register address width.

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-low reset.
- `aluop_i`  in  8  operation code, using the `EXE_*_OP` encodings from defines.
- `alusel_i`  in  3  result select, using the `EXE_RES_*` encodings.
- `reg1_i`, `reg2_i`  in  XLEN  source operands.
- `wd_i`  in  RAW  destination register address.
- `wreg_i`  in  1  write enable from decode.
- `flush_i`  in  1  pipeline flush; cancels any divide in progress.
- `wd_o`  out  RAW  destination register address, passed through.
- `wreg_o`  out  1  write enable.
- `wdata_o`  out  XLEN  result.
- `rem_o`  out  XLEN  divide remainder.
- `rem_we_o`  out  1  remainder write pulse.
- `stallreq_o`  out  1  request to hold the IF, ID and EX stages.

## Operation
- Logic ops, selected by `EXE_RES_LOGIC`:
  - OR, AND, XOR, NOR.
  - NOT is `~reg1_i`.
- Shift ops, selected by `EXE_RES_SHIFT`:
  - SLL, SRL, SRA shift `reg2_i` by `reg1_i[log2(XLEN)-1:0]`.
  - SRA replicates bit XLEN-1.
- Arithmetic ops, selected by `EXE_RES_ARITH`:
  - ADD and SUB are modulo 2^XLEN, with no overflow trap.
  - SLT is a signed compare and SLTU an unsigned compare; result is 1 or 0, zero-extended.
- Any unknown op or select gives `wdata_o` = 0. `wd_o` and `wreg_o` still pass through.
- Divide, selected by `EXE_RES_DIV` with DIV or DIVU, uses a restoring radix-2 FSM:
  - IDLE:
    - On a divide op with `reg2_i` = 0, go to DONE.
    - On a divide op with nonzero `reg2_i`, latch the operand magnitudes and the result signs, then go to CALC.
    - Otherwise stay in IDLE.
  - CALC: produce one quotient bit per cycle for XLEN cycles, counted by a log2(XLEN)+1-bit counter, then go to DONE.
  - DONE:
    - Present the sign-corrected result.
    - `wdata_o` = quotient, `rem_o` = remainder, `rem_we_o` = 1, `wreg_o` = `wreg_i`.
    - Go to IDLE next cycle.
- Sign rules for DIV:
  - Quotient is negative when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero: quotient is all ones; remainder equals the dividend.
- Signed overflow (minimum value / -1): quotient is the minimum value; remainder is 0.
- `stallreq_o` = 1 in IDLE when a divide op is present and `flush_i` = 0, and for the whole of CALC. It is 0 in DONE.
- Upstream holds `aluop_i`, `reg*_i` and `wd_i` stable while `stallreq_o` is high.
- While a divide is in progress (IDLE-with-divide-op or CALC), `wreg_o` = 0 and `rem_we_o` = 0.

## Timing
- Non-divide ops are combinational, with zero latency.
- Divide issued in cycle 0:
  - Cycles 1..XLEN are CALC.
  - Result is valid in cycle XLEN+1.
  - `stallreq_o` is high for XLEN+1 cycles.
- Divide by zero: result in cycle 1; stall lasts 1 cycle.
- `flush_i` high:
  - Next edge forces IDLE.
  - `stallreq_o` = 0 combinationally in the same cycle.
  - `wreg_o` and `rem_we_o` are forced to 0 in that cycle, including when the FSM is in DONE.
- Back-to-back divides: the second starts in the cycle after DONE. DONE always passes through IDLE.
- Reset (`rst` low, asynchronous, any state):
  - FSM returns to IDLE and the quotient, remainder and counter registers clear.
  - While reset is held, every output is 0.

## Configuration
- `EX_DIV_EN` defined: the divider FSM and its registers are built as described above.
- `EX_DIV_EN` undefined:
  - No divider logic is built.
  - DIV and DIVU produce `wdata_o` = 0, `rem_o` = 0 and `rem_we_o` = 0.
  - `stallreq_o` is tied to 0.

## Test plan
- XLEN=32, SRA with `reg1_i`=4, `reg2_i`=0x8000_0010 -> `wdata_o`=0xF800_0001 in the same cycle; SLTU with 1 vs 0xFFFF_FFFF -> 1.
- DIV -7 / 2 -> stall for 33 cycles; in cycle 33 `wdata_o`=0xFFFF_FFFD, `rem_o`=0xFFFF_FFFF, `rem_we_o`=1, `stallreq_o`=0.
- DIVU 100 / 0 -> `wdata_o`=0xFFFF_FFFF and `rem_o`=100 in cycle 1; stall lasts 1 cycle.
- DIV 0x8000_0000 / -1 -> quotient 0x8000_0000, remainder 0.
- `flush_i` pulsed in CALC cycle 10 -> FSM in IDLE next cycle, `stallreq_o`=0, no `rem_we_o` pulse; a following ADD 3+4 -> `wdata_o`=7 with no stall.
- `rst` asserted mid-CALC -> all outputs 0 immediately; after release a new DIVU 9/3 -> quotient 3, remainder 0 in cycle 33.
